// File: rtl/wsg_voice_mixer.sv
// Three-voice mixer: snapshots sample/volume pairs once per audio sample period,
// scales them through one shared 4x4 multiplier and offers the 10-bit sum to the DAC serializer.
module wsg_voice_mixer #(
    parameter int SAMPLE_DIV = 1042
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sample_1,
    input  logic [3:0] vol_1,
    input  logic [3:0] sample_2,
    input  logic [3:0] vol_2,
    input  logic [3:0] sample_3,
    input  logic [3:0] vol_3,
    input  logic       mute,
    input  logic       mix_ready,
    input  logic       overrun_clr,
    output logic [9:0] mix_out,
    output logic       mix_valid,
    output logic       sample_tick,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_V1   = 3'd1,
        S_V2   = 3'd2,
        S_V3   = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [3:0]    s1_q, s1_d, v1_q, v1_d;
    logic [3:0]    s2_q, s2_d, v2_q, v2_d;
    logic [3:0]    s3_q, s3_d, v3_q, v3_d;
    logic          mute_q, mute_d;
    logic [9:0]    acc_q, acc_d;
    logic [9:0]    mix_out_q, mix_out_d;
    logic          mix_valid_q, mix_valid_d;
    logic          overrun_q, overrun_d;

    logic [3:0]    op_s, op_v;
    logic [7:0]    prod;
    logic [9:0]    acc_sum;
    logic          transfer;

    // Handshake: a word moves when mix_valid & mix_ready; mix_out is frozen while
    // mix_valid is high and unaccepted; mix_ready has no effect while mix_valid is low.
    assign transfer = mix_valid_q & mix_ready;

    always_comb begin
        op_s = 4'd0;
        op_v = 4'd0;
        case (state_q)
            S_V1: begin op_s = s1_q; op_v = v1_q; end
            S_V2: begin op_s = s2_q; op_v = v2_q; end
            S_V3: begin op_s = s3_q; op_v = v3_q; end
            default: ;
        endcase
        prod    = {4'd0, op_s} * {4'd0, op_v};
        acc_sum = acc_q + {2'd0, prod};
    end

    always_comb begin
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        tick_d      = (cnt_d == CNT_LAST);
        state_d     = state_q;
        s1_d        = s1_q;
        v1_d        = v1_q;
        s2_d        = s2_q;
        v2_d        = v2_q;
        s3_d        = s3_q;
        v3_d        = v3_q;
        mute_d      = mute_q;
        acc_d       = acc_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = mix_valid_q & ~transfer;
        overrun_d   = overrun_q & ~overrun_clr;

        case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    s1_d    = sample_1;
                    v1_d    = vol_1;
                    s2_d    = sample_2;
                    v2_d    = vol_2;
                    s3_d    = sample_3;
                    v3_d    = vol_3;
                    mute_d  = mute;
                    acc_d   = 10'd0;
                    state_d = S_V1;
                end
            end
            S_V1: begin
                acc_d   = {2'd0, prod};
                state_d = S_V2;
            end
            S_V2: begin
                acc_d   = acc_sum;
                state_d = S_V3;
            end
            S_V3: begin
                acc_d   = acc_sum;
                state_d = S_OUT;
            end
            S_OUT: begin
                // A slot freed by a same-cycle transfer can take the new word immediately.
                if (!mix_valid_q || transfer) begin
                    mix_out_d   = mute_q ? 10'd0 : acc_q;
                    mix_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            s1_q        <= 4'd0;
            v1_q        <= 4'd0;
            s2_q        <= 4'd0;
            v2_q        <= 4'd0;
            s3_q        <= 4'd0;
            v3_q        <= 4'd0;
            mute_q      <= 1'b0;
            acc_q       <= 10'd0;
            mix_out_q   <= 10'd0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            s1_q        <= s1_d;
            v1_q        <= v1_d;
            s2_q        <= s2_d;
            v2_q        <= v2_d;
            s3_q        <= s3_d;
            v3_q        <= v3_d;
            mute_q      <= mute_d;
            acc_q       <= acc_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mix_out     = mix_out_q;
    assign mix_valid   = mix_valid_q;
    assign sample_tick = tick_q;
    assign overrun     = overrun_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_wsg_voice_mixer.sv
// Bench for wsg_voice_mixer: directed scenarios then random traffic, checked against
// a period-level model (pending results with due cycles, one output slot, expected queue).
module tb_wsg_voice_mixer;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sample_1 = '0, vol_1 = '0, sample_2 = '0, vol_2 = '0, sample_3 = '0, vol_3 = '0;
    logic       mute = 1'b0, mix_ready = 1'b1, overrun_clr = 1'b0;
    logic [9:0] mix_out;
    logic       mix_valid, sample_tick, overrun;
    logic [2:0] dbg_state;

    wsg_voice_mixer #(.SAMPLE_DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .sample_1(sample_1), .vol_1(vol_1),
        .sample_2(sample_2), .vol_2(vol_2),
        .sample_3(sample_3), .vol_3(vol_3),
        .mute(mute), .mix_ready(mix_ready), .overrun_clr(overrun_clr),
        .mix_out(mix_out), .mix_valid(mix_valid), .sample_tick(sample_tick),
        .overrun(overrun), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];

    typedef struct { int val; int due; } job_t;
    job_t pend_q[$];
    int   m_cnt   = 0;
    bit   m_valid = 1'b0;
    bit   m_ovr   = 1'b0;
    int   cyc     = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic int ref_mix(input int s1, v1, s2, v2, s3, v3, input bit mu);
        return mu ? 0 : s1 * v1 + s2 * v2 + s3 * v3;
    endfunction

    // Reference model: a tick captures the inputs; the result lands in the output
    // slot four cycles later if the slot is empty or being drained, else it is lost.
    always @(negedge clk) begin
        bit was_valid, xfer, busy, set_ovr;
        job_t j;
        chk("sample_tick", int'(sample_tick), int'(m_cnt == DIV - 1));
        chk("mix_valid", int'(mix_valid), int'(m_valid));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (rst) begin
            m_cnt   = 0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            pend_q.delete();
            exp_q.delete();
        end else begin
            was_valid = m_valid;
            xfer      = m_valid && mix_ready;
            busy      = (pend_q.size() != 0);
            set_ovr   = 1'b0;
            if (xfer) m_valid = 1'b0;
            if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                j = pend_q.pop_front();
                if (!was_valid || xfer) begin
                    m_valid = 1'b1;
                    exp_q.push_back(10'(j.val));
                end else begin
                    set_ovr = 1'b1;
                end
            end
            if (m_cnt == DIV - 1 && !busy) begin
                j.val = ref_mix(sample_1, vol_1, sample_2, vol_2, sample_3, vol_3, mute);
                j.due = cyc + 4;
                pend_q.push_back(j);
            end
            if (overrun_clr) m_ovr = 1'b0;
            if (set_ovr) m_ovr = 1'b1;
            m_cnt = (m_cnt + 1) % DIV;
        end
        cyc++;
    end

    // Monitor: a presented word must equal the oldest expected result; pop on transfer.
    always @(negedge clk) begin
        if (!rst && mix_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL mix_out_unexpected: got %0d with no result outstanding at %0t", mix_out, $time);
            end else begin
                chk("mix_out", int'(mix_out), int'(exp_q[0]));
                if (mix_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * DIV && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = sample_tick;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL wait_tick: got no sample_tick, required one within %0d cycles", 4 * DIV);
        end
    endtask

    task automatic set_in(input int s1, v1, s2, v2, s3, v3, input bit mu);
        sample_1 = 4'(s1); vol_1 = 4'(v1);
        sample_2 = 4'(s2); vol_2 = 4'(v2);
        sample_3 = 4'(s3); vol_3 = 4'(v3);
        mute = mu;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // full scale
        wait_tick();
        set_in(15, 15, 15, 15, 15, 15, 0);

        // mixed values; inputs change right after the tick
        wait_tick();
        set_in(3, 4, 10, 0, 7, 9, 0);
        cycles(1);
        set_in(15, 15, 15, 15, 15, 15, 0);

        // mute captured at the tick, then mute raised only after the tick
        wait_tick();
        set_in(3, 4, 10, 0, 7, 9, 1);
        cycles(1);
        mute = 1'b0;
        wait_tick();
        set_in(3, 4, 10, 0, 7, 9, 0);
        cycles(1);
        mute = 1'b1;

        // backpressure: hold first, drop second, then release and clear
        wait_tick();
        mix_ready = 1'b0;
        set_in(1, 2, 3, 4, 5, 6, 0);
        wait_tick();
        set_in(9, 9, 9, 9, 9, 9, 0);
        cycles(6);
        mix_ready = 1'b1;
        cycles(1);
        mix_ready   = 1'b0;
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;
        set_in(2, 3, 4, 5, 6, 7, 0);
        // the next result fills the slot, the one after is dropped while clear is asserted
        wait_tick();
        set_in(11, 12, 13, 14, 1, 1, 0);
        cycles(4);
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;
        mix_ready   = 1'b1;
        cycles(2);
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;

        // reset while the FSM is in V2
        wait_tick();
        set_in(5, 5, 6, 6, 7, 7, 0);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        wait_tick();
        set_in(8, 3, 2, 9, 14, 1, 0);
        wait_tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycles(1);
            set_in($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   ($urandom_range(0, 3) == 0));
            mix_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
        end

        // drain
        mix_ready   = 1'b1;
        overrun_clr = 1'b0;
        wait_tick();
        wait_tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
